// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width, line level
// and default clock/baud settings reused by the transmitter path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int   UART_DATA_W        = 8;
    localparam logic UART_IDLE_LEVEL    = 1'b1;
    localparam int   UART_CLK_FREQUENCY = 50000000;
    localparam int   UART_BAUD          = 9600;
    localparam int   UART_OVERSAMPLE    = 8;

    // Clocks per oversampling tick for a given clock, baud rate and oversample factor.
    function automatic int uart_tick_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider with synchronous restart; shared by the RX and TX paths.
module uart_baud_tick #(
    parameter int DIV = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tick_r;

    // Next divider count: restart or wrap to zero, otherwise advance.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (restart) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Divider state; the tick flop is precomputed so it is high exactly while the count sits at its wrap value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == CNT_MAX);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 oversampling UART receiver with sticky ready flag, framing-error,
// overrun and line-idle status.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = UART_CLK_FREQUENCY,
    parameter int BAUD          = UART_BAUD,
    parameter int OVERSAMPLE    = UART_OVERSAMPLE
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RxD,
    input  logic                   RxD_clear,
    output logic                   RxD_data_ready,
    output logic [UART_DATA_W-1:0] RxD_data,
    output logic                   RxD_idle,
    output logic                   RxD_frame_err,
    output logic                   RxD_overrun
);

    localparam int                 TICK_DIV   = uart_tick_div(CLK_FREQUENCY, BAUD, OVERSAMPLE);
    localparam int                 SAMP_W     = $clog2(OVERSAMPLE);
    localparam logic [SAMP_W-1:0]  MID_SAMPLE = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam int                 IDLE_MAX   = 2 * OVERSAMPLE * TICK_DIV;
    localparam int                 IDLE_W     = $clog2(IDLE_MAX + 1);
    localparam logic [IDLE_W-1:0]  IDLE_SAT   = IDLE_W'(IDLE_MAX);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("uart_receiver: CLK_FREQUENCY/(BAUD*OVERSAMPLE) must be at least 1");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE > 16) || ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_bad_oversample
        $error("uart_receiver: OVERSAMPLE must be a power of two in 4..16");
    end

    logic                   rx_meta_r;
    logic                   rx_sync_r;
    rx_state_t              state_r;
    logic [SAMP_W-1:0]      samp_cnt_r;
    logic [2:0]             bit_idx_r;
    logic [UART_DATA_W-1:0] shift_r;
    logic [UART_DATA_W-1:0] data_r;
    logic                   ready_r;
    logic                   frame_err_r;
    logic                   overrun_r;
    logic [IDLE_W-1:0]      idle_cnt_r;
    logic                   idle_r;
    logic                   tick_s;
    logic                   restart_s;
    logic                   mid_s;

    // Restarting the divider on the start edge centres every later sample on its bit.
    assign restart_s = (state_r == IDLE) && (rx_sync_r == 1'b0);
    assign mid_s     = tick_s && (samp_cnt_r == MID_SAMPLE);

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .CLK     (CLK),
        .RST     (RST),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_r <= UART_IDLE_LEVEL;
            rx_sync_r <= UART_IDLE_LEVEL;
        end else begin
            rx_meta_r <= RxD;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame FSM, shift register, ready flag and status pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            samp_cnt_r  <= '0;
            bit_idx_r   <= 3'd0;
            shift_r     <= '0;
            data_r      <= '0;
            ready_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            if (RxD_clear) begin
                ready_r <= 1'b0;
            end
            if (tick_s) begin
                samp_cnt_r <= samp_cnt_r + SAMP_W'(1);
            end
            case (state_r)
                IDLE: begin
                    if (!rx_sync_r) begin
                        state_r    <= START;
                        samp_cnt_r <= '0;
                    end
                end
                START: begin
                    if (mid_s) begin
                        if (rx_sync_r) begin
                            state_r <= IDLE;
                        end else begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (mid_s) begin
                        shift_r[bit_idx_r] <= rx_sync_r;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid-stop lets a following start bit arrive after a single stop bit.
                    if (mid_s) begin
                        if (rx_sync_r) begin
                            data_r    <= shift_r;
                            ready_r   <= 1'b1;
                            overrun_r <= ready_r && !RxD_clear;
                            state_r   <= IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_sync_r) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Line-idle detector: saturating run length of high samples while the FSM rests in IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idle_cnt_r <= '0;
            idle_r     <= 1'b0;
        end else begin
            if ((state_r != IDLE) || !rx_sync_r) begin
                idle_cnt_r <= '0;
            end else if (idle_cnt_r != IDLE_SAT) begin
                idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
            end else begin
                idle_cnt_r <= idle_cnt_r;
            end
            idle_r <= (state_r == IDLE) && (idle_cnt_r == IDLE_SAT);
        end
    end

    assign RxD_data_ready = ready_r;
    assign RxD_data       = data_r;
    assign RxD_idle       = idle_r;
    assign RxD_frame_err  = frame_err_r;
    assign RxD_overrun    = overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks per bit, with a byte-level
// expectation model (last good byte, sticky ready, expected overrun).
module tb_uart_receiver;

    localparam int BIT     = 16;
    localparam int LAT_NOM = 9 * BIT + BIT / 2 + 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RxD;
    logic       RxD_clear;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       RxD_idle;
    logic       RxD_frame_err;
    logic       RxD_overrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int rise_cyc = -1;
    int lat_meas = LAT_NOM;
    logic ready_d = 1'b0;

    logic       exp_ready;
    logic [7:0] exp_data;

    uart_receiver #(
        .CLK_FREQUENCY (1600000),
        .BAUD          (100000),
        .OVERSAMPLE    (8)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RxD            (RxD),
        .RxD_clear      (RxD_clear),
        .RxD_data_ready (RxD_data_ready),
        .RxD_data       (RxD_data),
        .RxD_idle       (RxD_idle),
        .RxD_frame_err  (RxD_frame_err),
        .RxD_overrun    (RxD_overrun)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse counters and ready rise time, sampled on the falling edge.
    always @(negedge CLK) begin
        if (RxD_frame_err === 1'b1) fe_cnt++;
        if (RxD_overrun === 1'b1) ov_cnt++;
        if (RxD_data_ready === 1'b1 && ready_d !== 1'b1) rise_cyc = cyc;
        ready_d = RxD_data_ready;
    end

    // Serialise one 8N1 frame starting at the current falling edge.
    task automatic send_frame(input logic [7:0] b, input int stop_low, output int start_cyc);
        start_cyc = cyc;
        RxD = 1'b0;
        repeat (BIT) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (BIT) @(negedge CLK);
        end
        if (stop_low > 0) begin
            RxD = 1'b0;
            repeat (stop_low) @(negedge CLK);
            RxD = 1'b1;
        end else begin
            RxD = 1'b1;
            repeat (BIT) @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        RxD = 1'b1;
        RxD_clear = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        exp_ready = 1'b0;
        exp_data = 8'h00;
        n_vec++; if (RxD_data_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", RxD_data_ready); end
        n_vec++; if (RxD_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", RxD_data); end
        n_vec++; if (RxD_frame_err !== 1'b0 || RxD_overrun !== 1'b0) begin n_err++; $display("FAIL reset_pulses got fe=%b ov=%b want 0 0", RxD_frame_err, RxD_overrun); end
        n_vec++; if (RxD_idle !== 1'b0) begin n_err++; $display("FAIL reset_idle got %b want 0", RxD_idle); end
    endtask

    task automatic test_idle_after_reset();
        bit seen;
        repeat (30) @(negedge CLK);
        n_vec++; if (RxD_idle !== 1'b0) begin n_err++; $display("FAIL idle_early got %b want 0 after 30 cycles", RxD_idle); end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge CLK);
            if (RxD_idle === 1'b1) seen = 1'b1;
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL idle_rise got 0 want 1 within 42 cycles"); end
    endtask

    task automatic test_single();
        int s;
        int lat;
        fe_cnt = 0; ov_cnt = 0; rise_cyc = -1;
        send_frame(8'hA5, 0, s);
        exp_ready = 1'b1; exp_data = 8'hA5;
        lat = rise_cyc - s;
        n_vec++; if (lat < 152 || lat > 156) begin n_err++; $display("FAIL single_latency got %0d want 152..156", lat); end
        else lat_meas = lat;
        n_vec++; if (RxD_data !== exp_data || RxD_data_ready !== exp_ready) begin n_err++; $display("FAIL single_byte got %h/%b want %h/%b", RxD_data, RxD_data_ready, exp_data, exp_ready); end
        n_vec++; if (fe_cnt != 0 || ov_cnt != 0) begin n_err++; $display("FAIL single_flags got fe=%0d ov=%0d want 0 0", fe_cnt, ov_cnt); end
        RxD_clear = 1'b1;
        @(negedge CLK);
        RxD_clear = 1'b0;
        exp_ready = 1'b0;
        n_vec++; if (RxD_data_ready !== exp_ready) begin n_err++; $display("FAIL clear_ready got %b want 0", RxD_data_ready); end
    endtask

    task automatic test_glitch();
        fe_cnt = 0; rise_cyc = -1;
        RxD = 1'b0;
        repeat (6) @(negedge CLK);
        RxD = 1'b1;
        repeat (40) @(negedge CLK);
        n_vec++; if (RxD_data_ready !== exp_ready || rise_cyc != -1) begin n_err++; $display("FAIL glitch_ready got %b want %b", RxD_data_ready, exp_ready); end
        n_vec++; if (fe_cnt != 0 || RxD_data !== exp_data) begin n_err++; $display("FAIL glitch_quiet got fe=%0d data=%h want 0 %h", fe_cnt, RxD_data, exp_data); end
    endtask

    task automatic test_frame_err();
        int s;
        bit seen;
        fe_cnt = 0; ov_cnt = 0;
        send_frame(8'h3C, 40, s);
        n_vec++; if (fe_cnt != 1) begin n_err++; $display("FAIL ferr_pulse got %0d want 1", fe_cnt); end
        n_vec++; if (RxD_data_ready !== exp_ready || RxD_data !== exp_data) begin n_err++; $display("FAIL ferr_keep got %b/%h want %b/%h", RxD_data_ready, RxD_data, exp_ready, exp_data); end
        repeat (28) @(negedge CLK);
        n_vec++; if (RxD_idle !== 1'b0) begin n_err++; $display("FAIL ferr_idle_early got %b want 0", RxD_idle); end
        seen = 1'b0;
        for (int i = 0; i < 14 && !seen; i++) begin
            @(negedge CLK);
            if (RxD_idle === 1'b1) seen = 1'b1;
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL ferr_idle_rise got 0 want 1"); end
    endtask

    task automatic test_back_to_back();
        int s;
        logic [7:0] a;
        logic [7:0] b;
        ov_cnt = 0; fe_cnt = 0;
        send_frame(8'h11, 0, s);
        n_vec++; if (RxD_data !== 8'h11 || RxD_data_ready !== 1'b1 || ov_cnt != 0) begin n_err++; $display("FAIL b2b_first got %h/%b ov=%0d want 11/1 0", RxD_data, RxD_data_ready, ov_cnt); end
        send_frame(8'h22, 0, s);
        n_vec++; if (RxD_data !== 8'h22 || RxD_data_ready !== 1'b1) begin n_err++; $display("FAIL b2b_second got %h/%b want 22/1", RxD_data, RxD_data_ready); end
        n_vec++; if (ov_cnt != 1 || fe_cnt != 0) begin n_err++; $display("FAIL b2b_overrun got ov=%0d fe=%0d want 1 0", ov_cnt, fe_cnt); end
        RxD_clear = 1'b1;
        @(negedge CLK);
        RxD_clear = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        ov_cnt = 0;
        send_frame(a, 0, s);
        fork
            send_frame(b, 0, s);
            begin
                repeat (lat_meas - 1) @(negedge CLK);
                RxD_clear = 1'b1;
                @(negedge CLK);
                RxD_clear = 1'b0;
            end
        join
        exp_ready = 1'b1; exp_data = b;
        n_vec++; if (RxD_data !== exp_data || RxD_data_ready !== exp_ready) begin n_err++; $display("FAIL clr_on_done got %h/%b want %h/1", RxD_data, RxD_data_ready, exp_data); end
        n_vec++; if (ov_cnt != 0) begin n_err++; $display("FAIL clr_on_done_ov got %0d want 0", ov_cnt); end
    endtask

    task automatic test_random();
        int s;
        logic [7:0] b;
        int mode;
        int exp_ov;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            mode = $urandom_range(0, 1);
            ov_cnt = 0;
            fork
                send_frame(b, 0, s);
                begin
                    repeat (40) @(negedge CLK);
                    if (mode == 1) begin
                        RxD_clear = 1'b1;
                        @(negedge CLK);
                        RxD_clear = 1'b0;
                    end
                end
            join
            if (mode == 1) exp_ready = 1'b0;
            exp_ov = exp_ready ? 1 : 0;
            exp_ready = 1'b1;
            exp_data = b;
            n_vec++; if (RxD_data !== exp_data) begin n_err++; $display("FAIL rand_data[%0d] got %h want %h", k, RxD_data, exp_data); end
            n_vec++; if (RxD_data_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready[%0d] got %b want 1", k, RxD_data_ready); end
            n_vec++; if (ov_cnt != exp_ov) begin n_err++; $display("FAIL rand_overrun[%0d] got %0d want %0d", k, ov_cnt, exp_ov); end
        end
    endtask

    task automatic test_reset_midframe();
        int s;
        fe_cnt = 0;
        fork
            send_frame(8'hFF, 0, s);
            begin
                repeat (5 * BIT + 8) @(negedge CLK);
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                exp_ready = 1'b0; exp_data = 8'h00;
                n_vec++; if (RxD_data_ready !== 1'b0 || RxD_data !== 8'h00) begin n_err++; $display("FAIL midrst_out got %b/%h want 0/00", RxD_data_ready, RxD_data); end
                n_vec++; if (RxD_idle !== 1'b0 || RxD_frame_err !== 1'b0 || RxD_overrun !== 1'b0) begin n_err++; $display("FAIL midrst_flags got %b%b%b want 000", RxD_idle, RxD_frame_err, RxD_overrun); end
            end
        join
        repeat (20) @(negedge CLK);
        n_vec++; if (RxD_data_ready !== exp_ready || fe_cnt != 0) begin n_err++; $display("FAIL midrst_ignored got ready=%b fe=%0d want 0 0", RxD_data_ready, fe_cnt); end
        send_frame(8'h5A, 0, s);
        exp_ready = 1'b1; exp_data = 8'h5A;
        n_vec++; if (RxD_data !== exp_data || RxD_data_ready !== exp_ready || fe_cnt != 0) begin n_err++; $display("FAIL midrst_next got %h/%b fe=%0d want 5a/1 0", RxD_data, RxD_data_ready, fe_cnt); end
    endtask

    initial begin
        RST = 1'b1;
        RxD = 1'b1;
        RxD_clear = 1'b0;
        @(negedge CLK);
        test_reset();
        test_idle_after_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
